// File: rtl/vta_pe_pkg.sv
// Shared helpers for the GEMM processing element.
// Saturating add and width utilities.
package vta_pe_pkg;

  localparam int SAT_WRAP  = 0;
  localparam int SAT_CLAMP = 1;
  localparam int ACC_MAX   = 64;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // a, b are sign-extended w-bit values; returns {ovf, sum}
  function automatic logic [ACC_MAX:0] sat_add(
    input logic [ACC_MAX-1:0] a,
    input logic [ACC_MAX-1:0] b,
    input int                 w,
    input logic               sat
  );
    logic [ACC_MAX-1:0] s;
    logic [ACC_MAX-1:0] mx;
    logic [5:0]         msb;
    logic               ovf;
    msb = 6'(w - 1);
    s   = a + b;
    mx  = (ACC_MAX'(1) << msb) - ACC_MAX'(1);
    ovf = (a[msb] == b[msb]) && (s[msb] != a[msb]);
    if (ovf && sat) s = a[msb] ? ~mx : mx;
    return {ovf, s};
  endfunction

endpackage

// File: rtl/mac_vec_tree.sv
// Balanced binary adder tree over the lane products.
// Leaves are sign-extended to the accumulator width.
module mac_vec_tree
  import vta_pe_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int PW        = 16,
  parameter int ACC_WIDTH = 32
) (
  input  logic [LANES*PW-1:0]  prods,
  output logic [ACC_WIDTH-1:0] sum
);

  localparam int NP = 1 << clog2(LANES);

  logic signed [ACC_WIDTH-1:0] node [1:2*NP-1];

  // heap-ordered tree: node i sums nodes 2i and 2i+1
  always_comb begin
    for (int i = 1; i < 2*NP; i++) node[i] = '0;
    for (int i = 0; i < LANES; i++)
      node[NP+i] = ACC_WIDTH'($signed(prods[i*PW +: PW]));
    for (int i = NP-1; i >= 1; i--)
      node[i] = node[2*i] + node[2*i+1];
    sum = node[1];
  end

endmodule

// File: rtl/mac_vec_pipe.sv
// Pipelined LANES-wide signed dot-product accumulator.
// Products, tree sum and accumulate each get a stage.
module mac_vec_pipe
  import vta_pe_pkg::*;
#(
  parameter int INP_WIDTH = 8,
  parameter int WGT_WIDTH = 8,
  parameter int ACC_WIDTH = 32,
  parameter int LANES     = 4,
  parameter int SAT       = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*INP_WIDTH-1:0]   in_inp,
  input  logic [LANES*WGT_WIDTH-1:0]   in_wgt,
  input  logic                         in_first,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_WIDTH-1:0]         out_sum,
  output logic                         out_ovf
);

  localparam int PW = INP_WIDTH + WGT_WIDTH;

  if (LANES < 1 || ACC_WIDTH >= ACC_MAX ||
      ACC_WIDTH < PW + clog2(LANES)) begin : g_bad_param
    $error("mac_vec_pipe: illegal parameters");
  end

  logic                 stall;
  logic                 adv;
  logic [LANES*PW-1:0]  prod;
  logic [LANES*PW-1:0]  s1_prod;
  logic                 s1_v, s1_first, s1_last;
  logic                 s2_v, s2_first, s2_last;
  logic [ACC_WIDTH-1:0] tree_sum, s2_sum;
  logic [ACC_WIDTH-1:0] acc, base, nxt;
  logic                 acc_clear, ovf_grp, ovf_nxt;
  logic [ACC_MAX:0]     add_r;
  logic                 unused_hi;

  assign stall    = out_valid && !out_ready;
  assign adv      = !stall;
  assign in_ready = adv && !rst;

  // lane multipliers, full-width signed products
  always_comb begin
    prod = '0;
    for (int i = 0; i < LANES; i++)
      prod[i*PW +: PW] =
        PW'($signed(in_inp[i*INP_WIDTH +: INP_WIDTH])) *
        PW'($signed(in_wgt[i*WGT_WIDTH +: WGT_WIDTH]));
  end

  // S1: register products with group flags
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v     <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
    end else if (adv) begin
      s1_v     <= in_valid;
      s1_first <= in_first;
      s1_last  <= in_last;
      s1_prod  <= prod;
    end
  end

  mac_vec_tree #(
    .LANES     (LANES),
    .PW        (PW),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_tree (
    .prods (s1_prod),
    .sum   (tree_sum)
  );

  // S2: register the reduced lane sum
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v     <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_sum   <= '0;
    end else if (adv) begin
      s2_v     <= s1_v;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_sum   <= tree_sum;
    end
  end

  // accumulate step; a new group starts on first or after a last
  always_comb begin
    base    = (s2_first || acc_clear) ? '0 : acc;
    add_r   = sat_add(ACC_MAX'($signed(base)),
                      ACC_MAX'($signed(s2_sum)),
                      ACC_WIDTH, SAT == SAT_CLAMP);
    nxt     = add_r[ACC_WIDTH-1:0];
    ovf_nxt = ((s2_first || acc_clear) ? 1'b0 : ovf_grp)
              | add_r[ACC_MAX];
  end

  assign unused_hi = ^add_r[ACC_MAX-1:ACC_WIDTH];

  // S3: accumulator and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      acc_clear <= 1'b1;
      ovf_grp   <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else if (adv) begin
      out_valid <= s2_v && s2_last;
      if (s2_v) begin
        if (s2_last) begin
          out_sum   <= nxt;
          out_ovf   <= ovf_nxt;
          acc       <= '0;
          acc_clear <= 1'b1;
          ovf_grp   <= 1'b0;
        end else begin
          acc       <= nxt;
          acc_clear <= 1'b0;
          ovf_grp   <= ovf_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_vec_pipe.sv
// Directed bench for mac_vec_pipe: 32-bit wrap,
// 18-bit clamp and 18-bit wrap instances share stimulus.
module tb_mac_vec_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_first, in_last, out_ready;
  logic [31:0] in_inp, in_wgt;
  logic        rdy0, rdy1, rdy2;
  logic        ov0, ov1, ov2;
  logic        of0, of1, of2;
  logic [31:0] s0;
  logic [17:0] s1, s2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mac_vec_pipe #(.ACC_WIDTH(32), .SAT(0)) u_d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .in_inp(in_inp), .in_wgt(in_wgt), .in_first(in_first),
    .in_last(in_last), .out_valid(ov0), .out_ready(out_ready),
    .out_sum(s0), .out_ovf(of0));

  mac_vec_pipe #(.ACC_WIDTH(18), .SAT(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .in_inp(in_inp), .in_wgt(in_wgt), .in_first(in_first),
    .in_last(in_last), .out_valid(ov1), .out_ready(out_ready),
    .out_sum(s1), .out_ovf(of1));

  mac_vec_pipe #(.ACC_WIDTH(18), .SAT(0)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
    .in_inp(in_inp), .in_wgt(in_wgt), .in_first(in_first),
    .in_last(in_last), .out_valid(ov2), .out_ready(out_ready),
    .out_sum(s2), .out_ovf(of2));

  typedef struct {
    logic [31:0] inp;
    logic [31:0] wgt;
    logic        first;
    logic        last;
    int          e0, e1, e2;
    int          o0, o1, o2;
  } vec_t;

  vec_t tbl [9];

  function automatic void check(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] w,
                      input logic f, input logic l);
    int n;
    n = 0;
    in_inp = a; in_wgt = w; in_first = f; in_last = l;
    in_valid = 1'b1;
    #1;
    while (!rdy0 && n < 20) begin
      tick();
      n++;
    end
    if (!rdy0) check("in_ready_wait", int'(rdy0), 1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{32'h04030201, 32'h08070605, 1'b1, 1'b1, 70, 70, 70, 0, 0, 0};
    tbl[1] = '{32'h80808080, 32'h80808080, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{32'h80808080, 32'h80808080, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0};
    tbl[3] = '{32'h80808080, 32'h80808080, 1'b0, 1'b1,
               196608, 131071, -65536, 0, 1, 1};
    tbl[4] = '{32'h01010101, 32'h01010101, 1'b0, 1'b1, 4, 4, 4, 0, 0, 0};
    tbl[5] = '{32'h7f7f7f7f, 32'h7f7f7f7f, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0};
    tbl[6] = '{32'h7f7f7f7f, 32'h7f7f7f7f, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0};
    tbl[7] = '{32'h7f7f7f7f, 32'h7f7f7f7f, 1'b0, 1'b1,
               193548, 131071, -68596, 0, 1, 1};
    tbl[8] = '{32'h7f7f7f7f, 32'h7f7f7f7f, 1'b0, 1'b1,
               64516, 64516, 64516, 0, 0, 0};

    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    in_inp = '0; in_wgt = '0; out_ready = 1'b1;
    tick(); tick();
    check("rdy_in_reset", int'(rdy0), 0);
    rst = 1'b0;
    tick();
    check("rst_out_valid", int'(ov0), 0);
    check("rst_out_sum", int'(s0), 0);
    check("rst_out_ovf", int'(of0), 0);
    check("rdy_after_reset", int'(rdy0), 1);

    // table-driven groups
    for (int k = 0; k < 9; k++) begin
      int n;
      send(tbl[k].inp, tbl[k].wgt, tbl[k].first, tbl[k].last);
      if (tbl[k].last) begin
        n = 0;
        while (!ov0 && n < 8) begin
          tick();
          n++;
        end
        check($sformatf("v%0d_valid", k), int'(ov0), 1);
        if (k == 0) check("latency", n + 1, 3);
        check($sformatf("v%0d_sum32", k), int'($signed(s0)), tbl[k].e0);
        check($sformatf("v%0d_sumsat", k), int'($signed(s1)), tbl[k].e1);
        check($sformatf("v%0d_sumwrap", k), int'($signed(s2)), tbl[k].e2);
        check($sformatf("v%0d_ovf32", k), int'(of0), tbl[k].o0);
        check($sformatf("v%0d_ovfsat", k), int'(of1), tbl[k].o1);
        check($sformatf("v%0d_ovfwrap", k), int'(of2), tbl[k].o2);
        tick();
      end
    end
    tick(); tick();

    // backpressure: out_ready low for cycles 4..8
    begin
      int c, sent, stalled, bad_rdy, bad_hold;
      int got[$];
      logic [31:0] held;
      logic hv;
      c = 0; sent = 0; stalled = 0; bad_rdy = 0; bad_hold = 0;
      hv = 1'b0; held = '0;
      while (got.size() < 6 && c < 60) begin
        out_ready = !(c >= 4 && c <= 8);
        in_valid = (sent < 6);
        in_inp = 32'(sent + 1); in_wgt = 32'd1;
        in_first = 1'b1; in_last = 1'b1;
        #1;
        if (ov0 && !out_ready) begin
          stalled++;
          if (rdy0) bad_rdy++;
          if (hv && s0 !== held) bad_hold++;
          held = s0;
          hv = 1'b1;
        end else begin
          hv = 1'b0;
        end
        if (in_valid && rdy0) sent++;
        if (ov0 && out_ready) got.push_back(int'(s0));
        tick();
        c++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      check("stall_count", got.size(), 6);
      for (int i = 0; i < got.size(); i++)
        check($sformatf("stall_res%0d", i), got[i], i + 1);
      check("stall_cycles", stalled, 5);
      check("stall_in_ready", bad_rdy, 0);
      check("stall_hold", bad_hold, 0);
    end
    tick(); tick();

    // full-rate stream of single-beat groups
    begin
      int c, sent, run, maxrun, nv, bad, exp;
      c = 0; sent = 0; run = 0; maxrun = 0; nv = 0; bad = 0; exp = 1;
      out_ready = 1'b1;
      while (c < 30) begin
        in_valid = (sent < 10);
        in_inp = 32'(sent + 1); in_wgt = 32'd1;
        in_first = 1'b1; in_last = 1'b1;
        #1;
        if (in_valid && rdy0) sent++;
        if (ov0) begin
          nv++;
          run++;
          if (int'(s0) != exp) bad++;
          exp++;
        end else begin
          run = 0;
        end
        if (run > maxrun) maxrun = run;
        tick();
        c++;
      end
      in_valid = 1'b0;
      check("stream_run", maxrun, 10);
      check("stream_count", nv, 10);
      check("stream_order", bad, 0);
    end
    tick(); tick();

    // reset mid-group and mid-stall
    begin
      int spur;
      out_ready = 1'b0;
      send(32'd9, 32'd1, 1'b1, 1'b1);
      send(32'h01010101, 32'h01010101, 1'b1, 1'b0);
      send(32'h01010101, 32'h01010101, 1'b0, 1'b0);
      check("rst_stall_setup", int'(ov0), 1);
      rst = 1'b1;
      #1;
      check("rdy_during_rst", int'(rdy0), 0);
      tick();
      rst = 1'b0;
      check("rst2_out_valid", int'(ov0), 0);
      check("rst2_out_sum", int'(s0), 0);
      check("rst2_out_ovf", int'(of0), 0);
      check("rst2_sum_sat", int'(s1), 0);
      out_ready = 1'b1;
      spur = 0;
      for (int i = 0; i < 5; i++) begin
        tick();
        if (ov0) spur++;
      end
      check("rst2_no_spurious", spur, 0);
      send(32'h02020202, 32'h02020202, 1'b0, 1'b1);
      begin
        int n;
        n = 0;
        while (!ov0 && n < 8) begin
          tick();
          n++;
        end
      end
      check("post_rst_valid", int'(ov0), 1);
      check("post_rst_sum", int'($signed(s0)), 16);
      check("post_rst_sumsat", int'($signed(s1)), 16);
      check("post_rst_ovf", int'(of0), 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
